matmul_stream_driver: RTL and testbench
=======================================

Name: matmul_stream_driver

Overview:
- Producer-side sequencer for the 8-lane matrix multiplier.
- Accepts a burst of K operand steps over a valid/ready load port. Each step is one 8-lane data column plus one broadcast weight. Steps are stored in an internal buffer.
- Replays the buffered steps into the multiplier as a clear pulse followed by K back-to-back valid cycles, then waits for the multiplier's done.
- Captures the MAC_NUM results and presents them on a valid/ready result port. A done-timeout watchdog guards the wait.

Parameters:
- DATA_WIDTH, 8, width of each lane operand.
- WEIGHT_WIDTH, 8, width of the broadcast weight.
- OUTPUT_WIDTH, 8, width of each lane result.
- MAC_NUM, 8, number of lanes.
- K_MAX, 16, operand buffer depth, i.e. maximum steps per job (power of two, ≥2).
- DONE_TIMEOUT, 64, cycles allowed in WAIT_DONE before abort (≥2).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rstn_i  in  1  synchronous active-low reset.
- ld_valid_i  in  1  load step valid.
- ld_ready_o  out  1  load step accepted when both high.
- ld_din_i  in  DATA_WIDTH*MAC_NUM  lane operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- ld_win_i  in  WEIGHT_WIDTH  step weight.
- ld_last_i  in  1  marks final step of job.
- mm_en_o  out  1  multiplier enable.
- mm_clear_o  out  1  multiplier accumulator clear.
- mm_valid_o  out  1  multiplier operand valid.
- mm_din_o  out  DATA_WIDTH*MAC_NUM  operands to multiplier.
- mm_win_o  out  WEIGHT_WIDTH  weight to multiplier.
- mm_done_i  in  1  multiplier done.
- mm_result_i  in  OUTPUT_WIDTH*MAC_NUM  multiplier results.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted when both high.
- res_data_o  out  OUTPUT_WIDTH*MAC_NUM  captured results.
- res_len_o  out  clog2(K_MAX)+1  step count of the job that produced res_data_o.
- busy_o  out  1  high in any state except LOAD.
- err_timeout_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rstn_i low at a clock edge):
  - State LOAD, count = 0.
  - All outputs 0, except ld_ready_o, which is 1 from the first cycle after reset.
  - Buffer contents are don't-care.
- LOAD:
  - ld_ready_o = 1.
  - On handshake: write the step to buffer[count], count += 1.
  - Leave to CLEAR when the accepted step has ld_last_i = 1, or when count reaches K_MAX (forced last; no error).
  - Latch len = count including the final step.
- CLEAR (1 cycle):
  - mm_clear_o = 1, mm_en_o = 1, mm_valid_o = 0.
  - Read pointer = 0. Next state STREAM.
- STREAM (exactly len cycles):
  - mm_en_o = 1, mm_valid_o = 1.
  - mm_din_o/mm_win_o = buffer[rd]; rd increments each cycle.
  - Operands must be registered, aligned with mm_valid_o.
  - After the len-th valid cycle, go to WAIT_DONE.
- WAIT_DONE:
  - mm_en_o = 1, mm_valid_o = 0. Timeout counter starts at 0 and increments each cycle.
  - On mm_done_i = 1: capture mm_result_i into res_data_o, res_len_o = len, go to RESULT.
  - If DONE_TIMEOUT cycles elapse without done: set err_timeout_o = 1, discard, go to LOAD with count = 0, no result.
  - mm_done_i in any other state is ignored.
- RESULT:
  - res_valid_o = 1; res_data_o and res_len_o stable until handshake.
  - mm_en_o = 0.
  - On res_ready_i = 1: go to LOAD with count = 0. res_valid_o drops the next cycle.
- Output gating:
  - ld_ready_o = 0 in all states except LOAD.
  - mm_din_o/mm_win_o are driven 0 when mm_valid_o = 0.
- err_timeout_o clears only on reset.
- Reset mid-job (any state): abort immediately to reset values. No clear or valid glitch is emitted in the reset cycle.
- Latency: first mm_valid_o occurs 2 cycles after the last-step handshake (1 cycle CLEAR entry, 1 cycle CLEAR).

Optional Feature:
- Macro MATMUL_DRV_PERF_EN.
- When defined:
  - Adds output perf_cycles_o (16 bits): cycles from entering CLEAR to entering RESULT, inclusive of CLEAR, saturating at 16'hFFFF.
  - Valid while res_valid_o = 1; reset value 0.
- When undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Load 4 steps (last on 4th), model returns done 3 cycles after last valid, res_ready_i = 1 → one mm_clear_o pulse, 4 consecutive mm_valid_o with operands in load order, res_valid_o one cycle after done, res_len_o = 4, res_data_o = captured mm_result_i.
- Load 16 steps with ld_last_i never high → forced last at 16th, ld_ready_o low from next cycle, 16 valid cycles, res_len_o = 16.
- Single-step job (ld_last_i on first) → clear then exactly 1 valid cycle, res_len_o = 1.
- Model never asserts done → after 64 WAIT_DONE cycles err_timeout_o = 1, no res_valid_o, ld_ready_o = 1, next job completes normally with err_timeout_o still 1.
- Hold res_ready_i low 5 cycles while pulsing mm_done_i with new data → res_data_o unchanged, ld_ready_o = 0 throughout, released on handshake.
- Assert rstn_i low mid-STREAM (step 2 of 8) → next cycle all outputs 0 except ld_ready_o = 1, busy_o = 0, a fresh 3-step job runs correctly.

Source files
------------

// File: rtl/matmul_stream_driver.sv
// matmul_stream_driver: buffers a K-step operand burst, replays it into the 8-lane multiplier, returns results.
// Optional MATMUL_DRV_PERF_EN adds perf_cycles_o (CLEAR-to-RESULT cycle count, saturating).
module matmul_stream_driver #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int OUTPUT_WIDTH = 8,
    parameter int MAC_NUM      = 8,
    parameter int K_MAX        = 16,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            ld_valid_i,
    output logic                            ld_ready_o,
    input  logic [DATA_WIDTH*MAC_NUM-1:0]   ld_din_i,
    input  logic [WEIGHT_WIDTH-1:0]         ld_win_i,
    input  logic                            ld_last_i,
    output logic                            mm_en_o,
    output logic                            mm_clear_o,
    output logic                            mm_valid_o,
    output logic [DATA_WIDTH*MAC_NUM-1:0]   mm_din_o,
    output logic [WEIGHT_WIDTH-1:0]         mm_win_o,
    input  logic                            mm_done_i,
    input  logic [OUTPUT_WIDTH*MAC_NUM-1:0] mm_result_i,
    output logic                            res_valid_o,
    input  logic                            res_ready_i,
    output logic [OUTPUT_WIDTH*MAC_NUM-1:0] res_data_o,
    output logic [$clog2(K_MAX):0]          res_len_o,
    output logic                            busy_o,
    output logic                            err_timeout_o
`ifdef MATMUL_DRV_PERF_EN
    ,
    output logic [15:0]                     perf_cycles_o
`endif
);
    localparam int AW = $clog2(K_MAX);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(DONE_TIMEOUT);
    localparam int SW = DATA_WIDTH * MAC_NUM + WEIGHT_WIDTH;
    localparam int RW = OUTPUT_WIDTH * MAC_NUM;

    typedef enum logic [2:0] {S_LOAD, S_CLEAR, S_STREAM, S_WAIT, S_RESULT} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d, len_q, len_d, rd_q, rd_d, rlen_q, rlen_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [SW-1:0]   op_q, op_d;
    logic [RW-1:0]   res_q, res_d;
    logic            err_q, err_d;
    logic [SW-1:0]   mem_q [K_MAX];
`ifdef MATMUL_DRV_PERF_EN
    logic [15:0]     perf_q, perf_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        rd_d    = rd_q;
        tmo_d   = tmo_q;
        op_d    = op_q;
        res_d   = res_q;
        rlen_d  = rlen_q;
        err_d   = err_q;
`ifdef MATMUL_DRV_PERF_EN
        perf_d  = (state_q == S_LOAD || state_q == S_RESULT || perf_q == 16'hFFFF) ? perf_q : perf_q + 16'd1;
`endif
        case (state_q)
            S_LOAD: if (ld_valid_i) begin
                cnt_d = cnt_q + LW'(1);
                // Hitting buffer depth ends the job exactly as an explicit last would.
                if (ld_last_i || cnt_d == LW'(K_MAX)) begin
                    len_d   = cnt_d;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
`ifdef MATMUL_DRV_PERF_EN
                    perf_d  = '0;
`endif
                end
            end
            S_CLEAR: begin
                op_d    = mem_q[0];
                rd_d    = LW'(1);
                state_d = S_STREAM;
            end
            S_STREAM: begin
                op_d    = mem_q[rd_q[AW-1:0]];
                rd_d    = rd_q + LW'(1);
                tmo_d   = '0;
                state_d = (rd_q == len_q) ? S_WAIT : S_STREAM;
            end
            S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (mm_done_i) begin
                    res_d   = mm_result_i;
                    rlen_d  = len_q;
                    state_d = S_RESULT;
                end else if (tmo_q == TW'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_RESULT: state_d = res_ready_i ? S_LOAD : S_RESULT;
            default:  state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            len_q   <= '0;
            rd_q    <= '0;
            tmo_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            rlen_q  <= '0;
            err_q   <= 1'b0;
`ifdef MATMUL_DRV_PERF_EN
            perf_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            op_q    <= op_d;
            res_q   <= res_d;
            rlen_q  <= rlen_d;
            err_q   <= err_d;
`ifdef MATMUL_DRV_PERF_EN
            perf_q  <= perf_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (ld_valid_i && ld_ready_o)
            mem_q[cnt_q[AW-1:0]] <= {ld_win_i, ld_din_i};
    end

    // Multiplier strobes are gated by reset so an aborted job cannot emit one more clear/valid.
    assign ld_ready_o             = state_q == S_LOAD;
    assign mm_en_o                = rstn_i && (state_q == S_CLEAR || state_q == S_STREAM || state_q == S_WAIT);
    assign mm_clear_o             = rstn_i && state_q == S_CLEAR;
    assign mm_valid_o             = rstn_i && state_q == S_STREAM;
    assign {mm_win_o, mm_din_o}   = mm_valid_o ? op_q : '0;
    assign res_valid_o            = state_q == S_RESULT;
    assign res_data_o             = res_q;
    assign res_len_o              = rlen_q;
    assign busy_o                 = state_q != S_LOAD;
    assign err_timeout_o          = err_q;
`ifdef MATMUL_DRV_PERF_EN
    assign perf_cycles_o          = perf_q;
`endif
endmodule

// File: tb/tb_matmul_stream_driver.sv
// tb_matmul_stream_driver: directed checks of load, replay, result, timeout and reset behaviour.
module tb_matmul_stream_driver;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        ld_valid = 1'b0, ld_last = 1'b0, mm_done = 1'b0, res_ready = 1'b0;
    logic [63:0] ld_din = '0, mm_result = '0;
    logic [7:0]  ld_win = '0;
    logic        ld_ready, mm_en, mm_clear, mm_valid, res_valid, busy, err;
    logic [63:0] mm_din, res_data;
    logic [7:0]  mm_win;
    logic [4:0]  res_len;
`ifdef MATMUL_DRV_PERF_EN
    logic [15:0] perf;
`endif
    int vecs = 0, errs = 0;

    matmul_stream_driver dut (
        .clk_i(clk), .rstn_i(rstn),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_din_i(ld_din), .ld_win_i(ld_win), .ld_last_i(ld_last),
        .mm_en_o(mm_en), .mm_clear_o(mm_clear), .mm_valid_o(mm_valid), .mm_din_o(mm_din), .mm_win_o(mm_win),
        .mm_done_i(mm_done), .mm_result_i(mm_result),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_len_o(res_len),
        .busy_o(busy), .err_timeout_o(err)
`ifdef MATMUL_DRV_PERF_EN
        , .perf_cycles_o(perf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int j);
        logic [63:0] b;
        b = 64'h0706050403020100;
        return b + {8{8'(j * 16)}};
    endfunction

    function automatic logic [7:0] wt(input int j);
        return 8'hA0 + 8'(j);
    endfunction

    task automatic load_stream(input int n, input bit use_last);
        for (int j = 0; j < n; j++) begin
            ld_valid = 1'b1;
            ld_din   = pat(j);
            ld_win   = wt(j);
            ld_last  = use_last && (j == n - 1);
            check("ld_ready_load", ld_ready, 1);
            step;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("clear_pulse", mm_clear, 1);
        check("clear_en", mm_en, 1);
        check("clear_valid", mm_valid, 0);
        check("clear_ld_ready", ld_ready, 0);
        check("clear_busy", busy, 1);
        for (int j = 0; j < n; j++) begin
            step;
            check("stream_valid", mm_valid, 1);
            check("stream_clear", mm_clear, 0);
            check("stream_din", mm_din, pat(j));
            check("stream_win", mm_win, wt(j));
        end
        step;
        check("wait_valid", mm_valid, 0);
        check("wait_din", mm_din, 0);
        check("wait_en", mm_en, 1);
    endtask

    task automatic finish(input int n, input int dly, input logic [63:0] r, input int hold);
        repeat (dly - 1) begin
            step;
            check("wait_no_res", res_valid, 0);
        end
        mm_done   = 1'b1;
        mm_result = r;
        step;
        mm_done   = 1'b0;
        mm_result = ~r;
        check("res_valid", res_valid, 1);
        check("res_data", res_data, r);
        check("res_len", 64'(res_len), 64'(n));
        check("res_en", mm_en, 0);
        check("res_ld_ready", ld_ready, 0);
`ifdef MATMUL_DRV_PERF_EN
        check("perf_cycles", 64'(perf), 64'(1 + n + dly));
`endif
        for (int h = 0; h < hold; h++) begin
            mm_done = 1'b1;
            step;
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, r);
            check("hold_ld_ready", ld_ready, 0);
        end
        mm_done   = 1'b0;
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        check("post_res_valid", res_valid, 0);
        check("post_ld_ready", ld_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        step;
        step;
        check("rst_ld_ready", ld_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_en", mm_en, 0);
        check("rst_clear", mm_clear, 0);
        check("rst_valid", mm_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_len", 64'(res_len), 0);
        check("rst_err", err, 0);
        rstn = 1'b1;
        step;

        load_stream(4, 1);
        finish(4, 3, 64'h1122334455667788, 0);
        load_stream(16, 0);
        finish(16, 2, 64'hDEADBEEFCAFEF00D, 0);
        load_stream(1, 1);
        finish(1, 1, 64'h0F0E0D0C0B0A0908, 0);

        load_stream(2, 1);
        repeat (63) step;
        check("tmo_still_wait", busy, 1);
        check("tmo_err_early", err, 0);
        step;
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_ld_ready", ld_ready, 1);
        check("tmo_res_valid", res_valid, 0);
        load_stream(3, 1);
        finish(3, 2, 64'hA5A5A5A55A5A5A5A, 0);
        check("tmo_err_sticky", err, 1);

        load_stream(2, 1);
        finish(2, 1, 64'h0123456789ABCDEF, 5);

        for (int j = 0; j < 8; j++) begin
            ld_valid = 1'b1;
            ld_din   = pat(j);
            ld_win   = wt(j);
            ld_last  = (j == 7);
            step;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        step;
        step;
        check("mid_stream_din", mm_din, pat(1));
        rstn = 1'b0;
        #1;
        check("rst_cycle_valid", mm_valid, 0);
        check("rst_cycle_clear", mm_clear, 0);
        step;
        rstn = 1'b1;
        check("mid_rst_ld_ready", ld_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", mm_en, 0);
        check("mid_rst_valid", mm_valid, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_res_valid", res_valid, 0);
        load_stream(3, 1);
        finish(3, 4, 64'h8877665544332211, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
